// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  // Width needed to hold a pattern length of 0..max_len.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Host-side bus of the sequence detector controller: config, control, bit stream, status.
interface seq_detect_ctrl_if
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) ();

  localparam int unsigned LEN_W = len_width(MAX_LEN);

  logic               cfg_valid;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_ready;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               bit_valid;
  logic               bit_in;
  logic               det_pulse;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;

  // Host side.
  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, bit_valid, bit_in,
    input  cfg_ready, cfg_err, det_pulse, match_cnt, busy, done
  );

  // Controller side.
  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, bit_valid, bit_in,
    output cfg_ready, cfg_err, det_pulse, match_cnt, busy, done
  );

endinterface

// File: rtl/seq_detect_ctrl_pattern_matcher.sv
// Shift-history pattern matcher: keeps the last MAX_LEN bits and how many are valid,
// and flags a combinational match of the low len bits against the pattern.
module pattern_matcher
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               bit_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  output logic               match_o
);

  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;

  // Candidate history/fill if the current bit is consumed, and the compare mask.
  always_comb begin
    hist_n = {hist_q[MAX_LEN-2:0], bit_i};
    fill_n = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    mask   = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_i);
    end
    match_o = enable_i && (fill_n >= len_i) && (((hist_n ^ pattern_i) & mask) == '0);
  end

  // History is frozen unless enabled; non-overlap mode restarts the fill after a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      fill_q <= '0;
    end else if (enable_i) begin
      hist_q <= hist_n;
      fill_q <= (match_o && !overlap_i) ? '0 : fill_n;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence detector controller: config registers, IDLE/SCAN/DONE FSM, match counter
// and registered status pulses around a shared pattern matcher.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  seq_detect_ctrl_if.slave bus
);

  localparam int unsigned LEN_W = len_width(MAX_LEN);

  state_e             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   target_q;
  logic               loaded_q;
  logic [CNT_W-1:0]   match_cnt_q;
  logic               det_pulse_q;
  logic               done_q;
  logic               cfg_err_q;

  logic               cfg_ok;
  logic               cfg_take;
  logic               start_ok;
  logic               scan_en;
  logic               match;
  logic [CNT_W-1:0]   cnt_inc;

  // Config acceptance, start qualification and saturating count increment.
  always_comb begin
    cfg_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    cfg_take = (state_q == StIdle) && bus.cfg_valid && cfg_ok;
    // A config landing with start in the same cycle arms the scan by itself.
    start_ok = (state_q == StIdle) && bus.start && (loaded_q || cfg_take);
    // Abort suppresses the match so it never counts.
    scan_en  = (state_q == StScan) && bus.bit_valid && !bus.abort;
    cnt_inc  = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + CNT_W'(1);
  end

  pattern_matcher #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_matcher (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (start_ok),
    .enable_i  (scan_en),
    .bit_i     (bus.bit_in),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .overlap_i (overlap_q),
    .match_o   (match)
  );

  // Controller FSM with config latching, counting and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pattern_q   <= '0;
      len_q       <= '0;
      overlap_q   <= 1'b0;
      target_q    <= '0;
      loaded_q    <= 1'b0;
      match_cnt_q <= '0;
      det_pulse_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      det_pulse_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cfg_valid) begin
            if (cfg_ok) begin
              pattern_q <= bus.cfg_pattern;
              len_q     <= bus.cfg_len;
              overlap_q <= bus.cfg_overlap;
              target_q  <= bus.cfg_target;
              loaded_q  <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          if (start_ok) begin
            state_q     <= StScan;
            match_cnt_q <= '0;
          end
        end
        StScan: begin
          if (bus.abort) begin
            state_q <= StIdle;
          end else if (match) begin
            det_pulse_q <= 1'b1;
            match_cnt_q <= cnt_inc;
            if ((target_q != '0) && (cnt_inc == target_q)) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.cfg_ready = (state_q == StIdle);
  assign bus.busy      = (state_q == StScan);
  assign bus.cfg_err   = cfg_err_q;
  assign bus.det_pulse = det_pulse_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.done      = done_q;

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Controller that configures, arms and sequences a programmable serial pattern detector. It replaces the family of fixed-pattern Moore detectors, such as the non-overlapping 11011 detector, with one runtime-loadable engine. Software or a host FSM loads a pattern, its length, overlap mode and a target match count, then starts a scan. The controller gates the serial bit stream into the shared matcher, counts detections, and reports completion or abort.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..16).
- CNT_W, 8: width of match counter and target.
- LEN_W, $clog2(MAX_LEN+1): width of cfg_len.

- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config write strobe.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first received bit, bit 0 the last.
- cfg_len  in  LEN_W  pattern length, valid range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  in  CNT_W  matches before completion; 0 = run until abort.
- cfg_ready  out  1  high in IDLE only.
- cfg_err  out  1  one-cycle pulse when a config is rejected.
- start  in  1  begin scan.
- abort  in  1  terminate scan.
- bit_valid  in  1  bit_in qualifier.
- bit_in  in  1  serial data.
- det_pulse  out  1  registered one-cycle pulse per match.
- match_cnt  out  CNT_W  matches in the current or last scan.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse on reaching the target.

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN: on start when cfg_loaded=1.
  - SCAN -> DONE: on the edge registering the match where match_cnt becomes cfg_target (target != 0).
  - SCAN -> IDLE: on abort.
  - DONE -> IDLE: unconditionally after one cycle.
- Config:
  - Accepted only in IDLE on cfg_valid. cfg_valid outside IDLE is ignored with no error.
  - cfg_len of 0 or greater than MAX_LEN: config dropped, previous config kept, cfg_err pulses the next cycle.
  - A valid config sets cfg_loaded.
- start:
  - Ignored in IDLE if cfg_loaded=0, and ignored in SCAN or DONE.
  - On an accepted start: match_cnt<=0 and history fill<=0.
  - cfg_valid and start in the same IDLE cycle: the new config is latched and the scan uses it.
- Matching, in SCAN on bit_valid:
  - hist_n = {hist[MAX_LEN-2:0], bit_in}.
  - fill_n = min(fill+1, MAX_LEN).
  - match when fill_n >= len and the low len bits of hist_n equal the low len bits of pattern.
- On match:
  - det_pulse<=1 and match_cnt<=match_cnt+1.
  - match_cnt saturates at 2^CNT_W-1 when target=0.
  - Non-overlap mode: fill<=0, so the next match needs len fresh bits.
  - Overlap mode: fill is kept.
- abort and match in the same cycle: abort wins; no det_pulse, no count increment; match_cnt otherwise holds.
- Bits outside SCAN are ignored and history is frozen. match_cnt holds its value in IDLE and DONE until the next start.

## Timing
- Reset values:
  - Outputs: det_pulse=0, match_cnt=0, busy=0, done=0, cfg_err=0, cfg_ready=1.
  - Internal: cfg_loaded=0, pattern=0, len=0, fill=0.
  - State: IDLE.
- rst mid-scan: everything returns to reset values on that edge; config is lost.
- busy and cfg_ready are decoded from the state register, so there is no extra latency.
- Detection latency: det_pulse is high in the cycle after the edge that samples the completing bit. match_cnt updates on that same edge.
- Final match: det_pulse and the DONE state coincide; done=1 in that cycle; IDLE follows next cycle.
- Start-to-first-sample: the first bit sampled is on the edge after start is accepted (the cycle after start).
- Back-to-back bit_valid every cycle is supported with no bubbles.

## Structure
- Package seq_detect_pkg: state enum (IDLE, SCAN, DONE) and the LEN_W derivation function.
- Sub-module pattern_matcher holds hist, fill, the mask-and-compare and the overlap clear. It takes clear, enable, bit_in, pattern, len and overlap, and outputs a combinational match.
- The top level holds the FSM, config registers, counter and output registers.

## Test plan
- Non-overlap 11011 (len=5, overlap=0, target=2), stream 1101101111011 -> det_pulse after bits 5 and 13, match_cnt=2, done pulse, return to IDLE.
- Same stream with overlap=1, target=0 -> det_pulse after bits 5, 8 and 13; match_cnt=3; busy stays high until abort.
- cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulse each time; prior config kept; start still scans with the old pattern.
- start with no config after reset -> stays IDLE, busy=0; cfg_valid+start together -> SCAN with the new config.
- abort on the cycle of a completing bit -> no det_pulse, match_cnt unchanged, IDLE next cycle, done=0.
- rst asserted mid-scan with match_cnt=3 -> next cycle all outputs at reset values, cfg_loaded=0, start ignored.
